regbank_pc: RTL
===============

// Module: regbank_pc
// PURPOSE
//  Parametrised general-purpose register bank for the processor datapath; one register is the
//  program counter (PC). The PC increments synchronously, can be loaded by normal writes, and has
//  a hardware return-address stack for Call/Ret.
//  Replaces the separate per-register instances and the asynchronous-increment PC register.
//  Sits between the control FSM (strobes) and the bus mux (QA/QB/PcOut).
// PARAMETERS
//  N           16          data width of every register, Target and stack entry
//  NREGS       8           number of registers (>=2); address width AW = $clog2(NREGS)
//  PC_IDX      NREGS-1     index of the register acting as PC
//  STACK_DEPTH 4           return-address stack entries (>=1); pointer width $clog2(STACK_DEPTH+1)
//  RESET_PC    0           PC value after reset
// PORTS
//  Clock     in   1    rising-edge clock for all state
//  Reset     in   1    asynchronous, active-high reset
//  WrEn      in   1    write WrData into register WrAddr at next edge
//  WrAddr    in   AW   write address; addresses >= NREGS are ignored
//  WrData    in   N    write data
//  RdAddrA   in   AW   read address, port A (addresses >= NREGS read 0)
//  RdAddrB   in   AW   read address, port B (addresses >= NREGS read 0)
//  QA        out  N    combinational read of register RdAddrA
//  QB        out  N    combinational read of register RdAddrB
//  PcIncr    in   1    PC <= PC+1 at next edge (replaces old Done/EnableI edge increment)
//  Call      in   1    push current PC, load PC <= Target
//  Ret       in   1    pop top of stack into PC
//  Target    in   N    call destination
//  PcOut     out  N    current PC (same as register PC_IDX)
//  Full      out  1    stack holds STACK_DEPTH entries
//  Empty     out  1    stack holds 0 entries
//  StackErr  out  1    sticky: overflow, underflow or Call&Ret collision; cleared only by Reset
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): all regs 0, PC=RESET_PC, stack ptr 0, StackErr 0.
//    So Empty=1, Full=0, QA/QB reflect reset contents immediately.
//    Stack entry contents are don't-care after reset.
//  - Reads: QA/QB/PcOut combinational from register state; a write is visible only after the edge.
//    No write-through bypass.
//  - Non-PC write: WrEn with WrAddr!=PC_IDX updates that register at the edge.
//    This is independent of any concurrent PC operation in the same cycle.
//  - PC next-value priority per cycle, highest first:
//     1 Call&Ret both high -> PC unchanged, stack unchanged, StackErr<=1
//     2 Ret: if !Empty -> PC<=stack[top], ptr--; if Empty -> PC unchanged, StackErr<=1
//     3 Call: if !Full -> stack[ptr]<=PC (pre-edge value), ptr++, PC<=Target;
//       if Full -> no push, PC unchanged, StackErr<=1
//     4 WrEn & WrAddr==PC_IDX -> PC<=WrData
//     5 PcIncr -> PC<=PC+1 modulo 2^N (wraps 2^N-1 -> 0, no flag)
//     6 otherwise PC holds
//  - Lower-priority PC requests in the same cycle are discarded, including:
//    Call (even a failed Call) overriding a PC write; a PC write overriding PcIncr.
//    A failed stack operation still suppresses any lower-priority PC update.
//  - Latency: every update takes effect at the first rising edge after the request.
//    Flags update with the pointer on the same edge.
//  - Full = (ptr==STACK_DEPTH); Empty = (ptr==0); both registered-state derived, no glitch on reads.
//  - Stack is LIFO; a Ret returns the most recent successful Call's saved PC.
//  - No asynchronous increment path; all PC changes are synchronous to Clock.
// TESTING
//  T1 reset: drive Reset mid-Call with RESET_PC=16'h0010.
//     -> PC=0010, R0..R6=0, Empty=1, StackErr=0 before the next edge.
//  T2 write/read: WrEn, WrAddr=3, WrData=BEEF.
//     -> QA(RdAddrA=3) shows old 0 same cycle, BEEF after edge; QB on addr 3 matches.
//  T3 PC increment wrap: write PC=FFFF, then PcIncr 2 cycles -> PcOut 0000 then 0001.
//     Then PcIncr with PC write of 1234 -> PC=1234.
//  T4 call/ret nesting: PC=0100, Call Target=0200, then Call Target=0300, then Ret twice
//     -> PC 0200, 0300, 0200, 0100; Empty=1 at end; StackErr=0.
//  T5 overflow/underflow: 5 Calls with STACK_DEPTH=4.
//     -> 5th leaves PC unchanged, Full=1, StackErr=1.
//     After Reset, Ret on empty -> PC unchanged, StackErr=1.
//  T6 collision: Call&Ret together with PcIncr and a PC write in the same cycle.
//     -> PC, stack unchanged, StackErr=1; concurrent write to R2 still lands.

Source files
------------

// File: rtl/regbank_pc.sv
// General-purpose register bank in which one register is the program counter.
// The PC steps synchronously and has a return-address stack behind Call/Ret.
module regbank_pc #(
  parameter int          N           = 16,
  parameter int          NREGS       = 8,
  parameter int          PC_IDX      = NREGS - 1,
  parameter int          STACK_DEPTH = 4,
  parameter logic [N-1:0] RESET_PC   = '0,
  localparam int         AW          = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int         PW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [N-1:0]  WrData,
  input  logic [AW-1:0] RdAddrA,
  input  logic [AW-1:0] RdAddrB,
  output logic [N-1:0]  QA,
  output logic [N-1:0]  QB,
  input  logic          PcIncr,
  input  logic          Call,
  input  logic          Ret,
  input  logic [N-1:0]  Target,
  output logic [N-1:0]  PcOut,
  output logic          Full,
  output logic          Empty,
  output logic          StackErr
);

  logic [N-1:0]  regs_q  [NREGS];
  logic [N-1:0]  regs_d  [NREGS];
  logic [N-1:0]  stack_q [STACK_DEPTH];
  logic [N-1:0]  stack_d [STACK_DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic          err_q, err_d;

  logic [N-1:0]  pc_cur;
  logic [N-1:0]  pc_next;
  logic [N-1:0]  stack_top;
  logic          full_w;
  logic          empty_w;
  logic          pc_write;

  assign pc_cur  = regs_q[PC_IDX];
  assign full_w  = (sp_q == PW'(STACK_DEPTH));
  assign empty_w = (sp_q == '0);

  // Unmapped read addresses return zero rather than aliasing a real register.
  always_comb begin
    QA = '0;
    QB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(RdAddrA) == i) QA = regs_q[i];
      if (int'(RdAddrB) == i) QB = regs_q[i];
    end
  end

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (int'(sp_q) == i + 1) stack_top = stack_q[i];
    end
  end

  assign pc_write = WrEn && (int'(WrAddr) == PC_IDX);

  // PC source priority: collision, Ret, Call, direct write, increment.
  // A rejected stack operation still blocks the lower-priority sources.
  always_comb begin
    pc_next = pc_cur;
    sp_d    = sp_q;
    err_d   = err_q;
    for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i];

    if (Call && Ret) begin
      err_d = 1'b1;
    end else if (Ret) begin
      if (empty_w) begin
        err_d = 1'b1;
      end else begin
        pc_next = stack_top;
        sp_d    = sp_q - PW'(1);
      end
    end else if (Call) begin
      if (full_w) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (int'(sp_q) == i) stack_d[i] = pc_cur;
        end
        sp_d    = sp_q + PW'(1);
        pc_next = Target;
      end
    end else if (pc_write) begin
      pc_next = WrData;
    end else if (PcIncr) begin
      pc_next = pc_cur + N'(1);
    end
  end

  // General registers take writes regardless of what the PC is doing.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i != PC_IDX && WrEn && int'(WrAddr) == i) regs_d[i] = WrData;
    end
    regs_d[PC_IDX] = pc_next;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
      end
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack entries are meaningless until pushed, so they carry no reset.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
  end

  assign PcOut    = pc_cur;
  assign Full     = full_w;
  assign Empty    = empty_w;
  assign StackErr = err_q;

endmodule
